// File: rtl/uart_ctrl_regs.sv
// uart_ctrl_regs -- UART register block.
//
// Holds the control and data registers and presents them as two 32-bit
// views for the downstream read mux. It also runs the TX launch handshake
// toward the transmitter engine and buffers received bytes in a small RX FIFO.
//
// Ports:
//   clk_i       system clock, all state updates on the rising edge
//   rst_n_i     synchronous reset, active low
//   reg_sel_i   register select: 0 = control, 1 = data
//   we_i        bus write strobe (one cycle per write)
//   wdata_i     bus write data
//   rd_i        bus read strobe; with reg_sel_i=1 it pops the RX FIFO
//   outc_o      control view:
//                 [0] SEND, [1] NEW_RX, [2] RX_OVF (W1C), [3] TX_BUSY,
//                 [4 +: CNT_W] RX count
//   outd_o      data view: {24'b0, FIFO head}, or 0 when the FIFO is empty
//   tx_data_o   byte handed to the TX engine, latched at launch
//   tx_start_o  one-cycle launch pulse
//   tx_rdy_i    TX engine idle / ready
//   rx_data_i   received byte
//   rx_valid_i  one-cycle strobe qualifying rx_data_i
//   irq_o       (only with UART_IRQ_EN) registered interrupt request
//
// Build option: define UART_IRQ_EN to add irq_o and the RXIE (bit 8) and
// TXIE (bit 9) control bits. Without it, bits 9:8 read 0 and are not writable.

module uart_ctrl_regs #(
    parameter int RX_DEPTH = 4,  // power of two, 2..16
    parameter int CNT_W    = 3   // 2**CNT_W must exceed RX_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        reg_sel_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic        rd_i,
    output logic [31:0] outc_o,
    output logic [31:0] outd_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_rdy_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i
`ifdef UART_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic             send_reg;
    logic             ovf_reg;
    logic [7:0]       hold_reg;
    logic [7:0]       tx_data_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       fifo_mem [RX_DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic ctrl_wr;
    logic data_wr;
    logic launch;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic ovf_set;
    logic tx_busy;

    assign ctrl_wr    = we_i && !reg_sel_i;
    assign data_wr    = we_i && reg_sel_i;
    assign launch     = (state_reg == ST_IDLE) && send_reg && tx_rdy_i;
    assign tx_busy    = (state_reg != ST_IDLE);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(RX_DEPTH));
    assign pop        = rd_i && reg_sel_i && !fifo_empty;
    // A push into a full FIFO still succeeds when a pop frees the head
    // slot in the same cycle; the write lands in the slot being vacated.
    assign push       = rx_valid_i && (!fifo_full || pop);
    assign ovf_set    = rx_valid_i && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Control / data registers and TX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            send_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            hold_reg    <= 8'h00;
            tx_data_reg <= 8'h00;
        end else begin
            // A bus write of SEND takes priority over the hardware clear
            // at launch, so a request written on that edge stays queued.
            if (ctrl_wr) begin
                send_reg <= wdata_i[0];
            end else if (launch) begin
                send_reg <= 1'b0;
            end

            // Overflow set wins over a simultaneous write-1-to-clear.
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ctrl_wr && wdata_i[2]) begin
                ovf_reg <= 1'b0;
            end

            if (data_wr) begin
                hold_reg <= wdata_i[7:0];
            end

            if (launch) begin
                tx_data_reg <= hold_reg;
            end

            case (state_reg)
                ST_IDLE:      if (launch)    state_reg <= ST_LAUNCH;
                ST_LAUNCH:                   state_reg <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (!tx_rdy_i) state_reg <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (tx_rdy_i)  state_reg <= ST_IDLE;
                default:                     state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (pointers wrap naturally since RX_DEPTH is a power of two)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset: every view of it is gated by the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rx_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Optional interrupt
    // ------------------------------------------------------------------
`ifdef UART_IRQ_EN
    logic rxie_reg;
    logic txie_reg;
    logic irq_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rxie_reg <= 1'b0;
            txie_reg <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rxie_reg <= wdata_i[8];
                txie_reg <= wdata_i[9];
            end
            irq_reg <= (rxie_reg && !fifo_empty)
                     | (rxie_reg && ovf_reg)
                     | (txie_reg && !send_reg && !tx_busy);
        end
    end

    assign irq_o = irq_reg;

    logic unused_wdata;
    assign unused_wdata = ^wdata_i[31:10];
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata_i[31:8];
`endif

    // ------------------------------------------------------------------
    // Read views (zero latency, built from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        outc_o              = 32'h0;
        outc_o[0]           = send_reg;
        outc_o[1]           = !fifo_empty;
        outc_o[2]           = ovf_reg;
        outc_o[3]           = tx_busy;
        outc_o[4 +: CNT_W]  = count_reg;
`ifdef UART_IRQ_EN
        outc_o[8]           = rxie_reg;
        outc_o[9]           = txie_reg;
`endif
    end

    assign outd_o     = fifo_empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr_reg]};
    assign tx_data_o  = tx_data_reg;
    assign tx_start_o = (state_reg == ST_LAUNCH);

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// tb_uart_ctrl_regs -- self-checking bench for uart_ctrl_regs.
//
// Directed steps walk through reset, a TX launch, FIFO fill/overflow/drain,
// push+pop on a full FIFO, overflow vs. clear, and reset with a pending
// request; a randomized phase follows. After every clock edge all outputs
// are compared with a behavioural model (byte queue, sticky flag, TX phase).

module tb_uart_ctrl_regs;

    localparam int RX_DEPTH = 4;
    localparam int CNT_W    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        rd = 1'b0;
    logic        tx_rdy = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [31:0] outc;
    logic [31:0] outd;
    logic [7:0]  tx_data;
    logic        tx_start;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [7:0] m_q[$];
    bit         m_send;
    bit         m_ovf;
    int         m_phase;   // 0 idle, 1 launch pulse, 2 awaiting engine busy, 3 awaiting engine done
    logic [7:0] m_hold;
    logic [7:0] m_txd;
`ifdef UART_IRQ_EN
    bit         m_rxie;
    bit         m_txie;
    bit         m_irq;
`endif

    always #5 clk = ~clk;

    uart_ctrl_regs #(.RX_DEPTH(RX_DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .reg_sel_i (reg_sel),
        .we_i      (we),
        .wdata_i   (wdata),
        .rd_i      (rd),
        .outc_o    (outc),
        .outd_o    (outd),
        .tx_data_o (tx_data),
        .tx_start_o(tx_start),
        .tx_rdy_i  (tx_rdy),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid)
`ifdef UART_IRQ_EN
        ,
        .irq_o     (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_outc();
        logic [31:0] v;
        v = 32'h0;
        v[0] = m_send;
        v[1] = (m_q.size() != 0);
        v[2] = m_ovf;
        v[3] = (m_phase != 0);
        v[4 +: CNT_W] = CNT_W'(m_q.size());
`ifdef UART_IRQ_EN
        v[8] = m_rxie;
        v[9] = m_txie;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_outd();
        if (m_q.size() == 0) return 32'h0;
        return {24'h0, m_q[0]};
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        bit launch;
        bit full;
        bit pop;
        if (!rst_n) begin
            m_q.delete();
            m_send = 0; m_ovf = 0; m_phase = 0; m_hold = 8'h0; m_txd = 8'h0;
`ifdef UART_IRQ_EN
            m_rxie = 0; m_txie = 0; m_irq = 0;
`endif
            return;
        end
`ifdef UART_IRQ_EN
        m_irq = (m_rxie && m_q.size() != 0) || (m_rxie && m_ovf) ||
                (m_txie && !m_send && m_phase == 0);
        if (we && !reg_sel) begin
            m_rxie = wdata[8];
            m_txie = wdata[9];
        end
`endif
        launch = (m_phase == 0) && m_send && tx_rdy;
        full   = (m_q.size() == RX_DEPTH);
        pop    = rd && reg_sel && (m_q.size() != 0);

        if (launch) m_txd = m_hold;
        if (we && !reg_sel) m_send = wdata[0];
        else if (launch) m_send = 0;
        if (we && reg_sel) m_hold = wdata[7:0];

        case (m_phase)
            0: if (launch) m_phase = 1;
            1: m_phase = 2;
            2: if (!tx_rdy) m_phase = 3;
            3: if (tx_rdy) m_phase = 0;
            default: m_phase = 0;
        endcase

        if (pop) void'(m_q.pop_front());
        if (rx_valid) begin
            if (!full || pop) m_q.push_back(rx_data);
            else begin
                m_ovf = 1;
            end
        end
        if (!(rx_valid && full && !pop) && we && !reg_sel && wdata[2]) m_ovf = 0;
    endtask

    // One clock: log the bus transaction, clock it, update model, compare.
    task automatic tick();
        if (we)
            $display("[TB] t=%0t write %s 0x%08h", $time, reg_sel ? "data" : "ctrl", wdata);
        else if (rd && reg_sel)
            $display("[TB] t=%0t read  data 0x%08h", $time, outd);
        @(posedge clk);
        model_step();
        #1;
        check("outc", outc, exp_outc());
        check("outd", outd, exp_outd());
        check("tx_start", {31'h0, tx_start}, {31'h0, m_phase == 1});
        check("tx_data", {24'h0, tx_data}, {24'h0, m_txd});
`ifdef UART_IRQ_EN
        check("irq", {31'h0, irq}, {31'h0, m_irq});
`endif
    endtask

    task automatic idle_inputs();
        we = 0; rd = 0; rx_valid = 0; reg_sel = 0; wdata = 32'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        idle_inputs(); rx_valid = 1; rx_data = b; tick(); idle_inputs();
    endtask

    task automatic pop_byte();
        idle_inputs(); rd = 1; reg_sel = 1; tick(); idle_inputs();
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] d);
        idle_inputs(); we = 1; reg_sel = sel; wdata = d; tick(); idle_inputs();
    endtask

    logic [7:0] seq_a [5];

    initial begin
        seq_a[0] = 8'h11; seq_a[1] = 8'h22; seq_a[2] = 8'h33; seq_a[3] = 8'h44; seq_a[4] = 8'h55;

        // Reset and read both views
        rst_n = 0; tick(); tick();
        rst_n = 1; tick();
        check("reset_outc", outc, 32'h0);
        check("reset_outd", outd, 32'h0);
        check("reset_tx_start", {31'h0, tx_start}, 32'h0);

        // TX launch: data then SEND with the engine ready
        tx_rdy = 1;
        write_reg(1'b1, 32'h1234_56A5);
        write_reg(1'b0, 32'h0000_0001);
        check("send_set", {31'h0, outc[0]}, 32'h1);
        check("launch_not_yet", {31'h0, tx_start}, 32'h0);
        tick();
        check("launch_pulse", {31'h0, tx_start}, 32'h1);
        check("launch_data", {24'h0, tx_data}, 32'h0000_00A5);
        check("send_cleared", {31'h0, outc[0]}, 32'h0);
        check("busy_at_launch", {31'h0, outc[3]}, 32'h1);
        tick();
        check("pulse_one_cycle", {31'h0, tx_start}, 32'h0);
        write_reg(1'b1, 32'h0000_00C3);   // data write mid-transfer
        check("tx_data_held", {24'h0, tx_data}, 32'h0000_00A5);
        tx_rdy = 0; tick();
        check("busy_engine_busy", {31'h0, outc[3]}, 32'h1);
        tx_rdy = 1; tick();
        check("idle_after_done", {31'h0, outc[3]}, 32'h0);

        // Fill past capacity, then drain
        for (int i = 0; i < 5; i++) push_byte(seq_a[i]);
        check("fill_count", {29'h0, outc[6:4]}, 32'h4);
        check("fill_ovf", {31'h0, outc[2]}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", outd, {24'h0, seq_a[i]});
            pop_byte();
        end
        check("drain_empty", outd, 32'h0);
        check("drain_new_rx", {31'h0, outc[1]}, 32'h0);
        pop_byte();   // pop on empty is ignored
        check("empty_pop_count", {29'h0, outc[6:4]}, 32'h0);
        write_reg(1'b0, 32'h0000_0004);
        check("ovf_w1c", {31'h0, outc[2]}, 32'h0);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 4; i++) push_byte(seq_a[i]);
        idle_inputs(); rx_valid = 1; rx_data = 8'h66; rd = 1; reg_sel = 1; tick(); idle_inputs();
        check("pp_no_ovf", {31'h0, outc[2]}, 32'h0);
        check("pp_count", {29'h0, outc[6:4]}, 32'h4);
        check("pp_head", outd, 32'h0000_0022);
        for (int i = 0; i < 3; i++) pop_byte();
        check("pp_last", outd, 32'h0000_0066);

        // Overflowing push in the same cycle as the W1C
        push_byte(8'h77); push_byte(8'h88); push_byte(8'h99);
        idle_inputs(); rx_valid = 1; rx_data = 8'hAA; we = 1; reg_sel = 0; wdata = 32'h4; tick(); idle_inputs();
        check("ovf_set_wins", {31'h0, outc[2]}, 32'h1);
        write_reg(1'b0, 32'h0000_0004);
        check("ovf_cleared", {31'h0, outc[2]}, 32'h0);

        // Pending SEND dropped by reset
        tx_rdy = 0;
        write_reg(1'b0, 32'h0000_0001);
        check("send_pending", {31'h0, outc[0]}, 32'h1);
        rst_n = 0; tick();
        rst_n = 1;
        check("send_after_reset", {31'h0, outc[0]}, 32'h0);
        tx_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_launch_after_reset", {31'h0, tx_start}, 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            we       = ($urandom_range(0, 3) == 0);
            reg_sel  = $urandom_range(0, 1);
            wdata    = $urandom();
            rd       = ($urandom_range(0, 9) < 3);
            rx_valid = ($urandom_range(0, 9) < 4);
            rx_data  = 8'($urandom());
            tx_rdy   = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
